gpio_in_filter: RTL

- Input conditioning stage directly upstream of the APB GPIO block; its output drives that block's gpio_in bus.
- Per-pin multi-flop synchroniser, then an optional per-pin debounce filter clocked by a shared sample-tick prescaler.
- Emits clean levels plus single-cycle rise/fall pulses, so the downstream interrupt, strap and input-register logic only ever see stable, synchronous inputs.

---
 rtl/gpio_in_filter_if.sv | 28 ++
 rtl/gpio_in_filter.sv | 117 +++++++++++
 2 files changed

// File: rtl/gpio_in_filter_if.sv
// Pad-side conditioning bus: raw pads and filter controls in, clean levels, edge pulses and tick out.
// master = the block driving pads/controls, slave = gpio_in_filter.
interface gpio_in_filter_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8,
  parameter int PRE_W = 16
);
  logic [WIDTH-1:0] pad_in;
  logic [WIDTH-1:0] filt_en;
  logic [CNT_W-1:0] debounce_len;
  logic [PRE_W-1:0] prescale;
  logic             glitch_clr;
  logic [WIDTH-1:0] gpio_clean;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic             tick;
  logic [15:0]      glitch_count;

  modport master (
    output pad_in, filt_en, debounce_len, prescale, glitch_clr,
    input  gpio_clean, rise_pulse, fall_pulse, tick, glitch_count
  );

  modport slave (
    input  pad_in, filt_en, debounce_len, prescale, glitch_clr,
    output gpio_clean, rise_pulse, fall_pulse, tick, glitch_count
  );
endinterface

// File: rtl/gpio_in_filter.sv
// Per-pin synchroniser plus tick-sampled debounce; bypass latency SYNC_STAGES+1, no backpressure.
// Optional glitch counter under GPIO_IN_FILTER_GLITCH_CNT_EN (else glitch_count tied to 0).
module gpio_in_filter #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int PRE_W       = 16
) (
  input logic              PCLK,
  input logic              PRESETn,
  gpio_in_filter_if.slave  bus
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_w;
  logic [PRE_W-1:0] pre_q;
  logic             run_q;
  logic             tick_w;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [WIDTH-1:0] clean_q;
  logic [WIDTH-1:0] clean_nxt;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= bus.pad_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_w = sync_q[SYNC_STAGES-1];

  // run_q keeps tick low while reset is held even though the counter sits at 0
  assign tick_w = run_q & (pre_q == '0);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pre_q <= '0;
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (tick_w)
        pre_q <= bus.prescale;
      else if (run_q)
        pre_q <= pre_q - PRE_W'(1);
    end
  end

  always_comb begin
    clean_nxt = clean_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (!bus.filt_en[i])
        clean_nxt[i] = sync_w[i];
      else if (tick_w && (sync_w[i] != clean_q[i]) && (cnt_q[i] >= bus.debounce_len))
        clean_nxt[i] = sync_w[i];
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!bus.filt_en[i])
          cnt_q[i] <= '0;
        else if (tick_w) begin
          // accepting or seeing agreement both restart the stability count
          if ((sync_w[i] == clean_q[i]) || (cnt_q[i] >= bus.debounce_len))
            cnt_q[i] <= '0;
          else
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
      clean_q <= clean_nxt;
      rise_q  <= clean_nxt & ~clean_q;
      fall_q  <= ~clean_nxt & clean_q;
    end
  end

  assign bus.gpio_clean = clean_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.tick       = tick_w;

`ifdef GPIO_IN_FILTER_GLITCH_CNT_EN
  logic [WIDTH-1:0] rej_w;
  logic [15:0]      glitch_q;

  always_comb begin
    rej_w = '0;
    for (int i = 0; i < WIDTH; i++)
      rej_w[i] = bus.filt_en[i] & tick_w & (sync_w[i] == clean_q[i]) & (cnt_q[i] != '0);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)
      glitch_q <= '0;
    else if (bus.glitch_clr)
      glitch_q <= '0;
    else if ((|rej_w) && (glitch_q != 16'hFFFF))
      glitch_q <= glitch_q + 16'd1;
  end

  assign bus.glitch_count = glitch_q;
`else
  logic unused_glitch_clr;
  assign unused_glitch_clr = bus.glitch_clr;
  assign bus.glitch_count  = '0;
`endif

endmodule
